// File: rtl/ibex_pkg.sv
// Shared types for the CHERI memory-check queue, plus the wrap64 capability field helpers.
// Capability layout (91 bits): {tag, perms[3:1], otype[21:0], top[32:0], base[31:0]}.
package ibex_pkg;

  localparam int unsigned MemchkMaxDepth = 8;
  localparam int unsigned Wrap64CapW     = 91;
  localparam int unsigned PermitExecute  = 1;
  localparam int unsigned PermitLoad     = 2;
  localparam int unsigned PermitStore    = 3;

  typedef enum logic [1:0] {
    DataWord   = 2'b00,
    DataHalf   = 2'b01,
    DataByte   = 2'b10,
    DataDouble = 2'b11
  } data_type_e;

  typedef struct packed {
    logic tag_violation;
    logic seal_violation;
    logic execute_violation;
    logic load_violation;
    logic store_violation;
    logic length_violation;
  } cheri_exc_t;

  typedef struct packed {
    cheri_exc_t exc;
    logic       upper;
    logic       upper_2;
  } memchk_entry_t;

  typedef struct packed {
    logic                              tag;
    logic [PermitStore:PermitExecute]  perms;
    logic [21:0]                       otype;
    logic [32:0]                       top;
    logic [31:0]                       base;
  } wrap64_cap_t;

  function automatic logic wrap64_isValidCap(wrap64_cap_t cap);
    return cap.tag;
  endfunction

  function automatic logic [PermitStore:PermitExecute] wrap64_getPerms(wrap64_cap_t cap);
    return cap.perms;
  endfunction

  function automatic logic [21:0] wrap64_getKind(wrap64_cap_t cap);
    return cap.otype;
  endfunction

  function automatic logic [32:0] wrap64_getTop(wrap64_cap_t cap);
    return cap.top;
  endfunction

  function automatic logic [31:0] wrap64_getBase(wrap64_cap_t cap);
    return cap.base;
  endfunction

endpackage

// File: rtl/ibex_cheri_bounds_check.sv
// Combinational capability check of one access: tag, seal, permission and bounds faults.
module ibex_cheri_bounds_check import ibex_pkg::*; #(
  parameter bit          DataMem       = 1'b1,
  parameter int unsigned CheriCapWidth = 91
) (
  input  logic [CheriCapWidth-1:0] cap_i,
  input  logic [31:0]              addr_i,
  input  logic [1:0]               type_i,
  input  logic [3:0]               be_i,
  input  logic                     we_i,
  output memchk_entry_t            entry_o
);

  wrap64_cap_t                      cap;
  logic [31:0]                      base;
  logic [32:0]                      top;
  logic [PermitStore:PermitExecute] perms;
  logic [1:0]                       be_low;
  logic [3:0]                       size;
  logic [31:0]                      data_addr;
  logic [31:0]                      instr_end;
  logic [31:0]                      instr_end_2;
  logic                             len_data;
  logic                             len_instr;

  assign cap   = wrap64_cap_t'(Wrap64CapW'(cap_i));
  assign base  = wrap64_getBase(cap);
  assign top   = wrap64_getTop(cap);
  assign perms = wrap64_getPerms(cap);

  always_comb begin
    be_low = 2'd3;
    if (be_i[0])      be_low = 2'd0;
    else if (be_i[1]) be_low = 2'd1;
    else if (be_i[2]) be_low = 2'd2;
  end

  always_comb begin
    size = 4'd8;
    case (data_type_e'(type_i))
      DataWord: size = 4'd4;
      DataHalf: size = 4'd2;
      DataByte: size = 4'd1;
      default:  size = 4'd8;
    endcase
  end

  // Data end is formed in 33 bits so accesses touching 2^32 are not wrapped;
  // instruction end deliberately wraps in 32 bits before the compare.
  assign data_addr   = {addr_i[31:2], be_low};
  assign len_data    = (data_addr < base) | (({1'b0, data_addr} + {29'd0, size}) > top);
  assign instr_end   = addr_i + 32'd2;
  assign instr_end_2 = addr_i + 32'd6;
  assign len_instr   = (addr_i < base) | ({1'b0, instr_end} > top);

  always_comb begin
    entry_o = '0;
    entry_o.exc.tag_violation     = ~wrap64_isValidCap(cap);
    entry_o.exc.seal_violation    = |wrap64_getKind(cap);
    entry_o.exc.load_violation    = ~we_i & DataMem & ~perms[PermitLoad];
    entry_o.exc.store_violation   = we_i & ~perms[PermitStore];
    entry_o.exc.execute_violation = ~DataMem & ~perms[PermitExecute];
    entry_o.exc.length_violation  = DataMem ? len_data : len_instr;
    if (!DataMem) begin
      entry_o.upper   = {1'b0, addr_i[31:2], 2'b11} >= top;
      entry_o.upper_2 = {1'b0, instr_end_2} > top;
    end
  end

endmodule

// File: rtl/ibex_cheri_memcheck_queue.sv
// Checks each granted memory beat against the authorising capability and queues the
// result until the matching response returns, so faults line up with rvalid.
module ibex_cheri_memcheck_queue import ibex_pkg::*; #(
  parameter bit          DataMem       = 1'b1,
  parameter int unsigned CheriCapWidth = 91,
  parameter int unsigned Depth         = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CheriCapWidth-1:0]   auth_cap_i,
  input  logic                       data_req_i,
  input  logic                       data_gnt_i,
  input  logic                       data_rvalid_i,
  input  logic                       data_we_i,
  input  logic                       data_first_access_i,
  input  logic [31:0]                data_addr_i,
  input  logic [1:0]                 data_type_i,
  input  logic [3:0]                 data_be_i,
  output logic                       data_req_o,
  output logic                       data_we_o,
  output cheri_exc_t                 rsp_exc_o,
  output logic                       rsp_exc_valid_o,
  output logic                       rsp_upper_exc_o,
  output logic                       rsp_upper_exc_2_o,
  output logic [$clog2(Depth+1)-1:0] outstanding_o,
  output logic                       full_o,
  output logic                       underflow_err_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  memchk_entry_t   entries_q [Depth];
  memchk_entry_t   held_q;
  memchk_entry_t   chk_entry;
  memchk_entry_t   push_entry;
  memchk_entry_t   rsp_entry;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            underflow_q;
  logic            first_beat;
  logic            push;
  logic            pop;
  logic            empty;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  ibex_cheri_bounds_check #(
    .DataMem       (DataMem),
    .CheriCapWidth (CheriCapWidth)
  ) u_bounds_check (
    .cap_i   (auth_cap_i),
    .addr_i  (data_addr_i),
    .type_i  (data_type_i),
    .be_i    (data_be_i),
    .we_i    (data_we_i),
    .entry_o (chk_entry)
  );

  // Second half of a split access reuses the first beat's verdict.
  assign first_beat = ~DataMem | data_first_access_i;
  assign push_entry = first_beat ? chk_entry : held_q;

  assign outstanding_o = rst_i ? '0 : count_q;
  assign full_o        = (outstanding_o == CntW'(Depth));
  assign empty         = (count_q == '0);

  assign data_req_o = data_req_i & ~full_o;
  assign data_we_o  = data_we_i & ~(|push_entry.exc);

  assign push = data_req_o & data_gnt_i;
  assign pop  = data_rvalid_i & ~empty & ~rst_i;

  assign rsp_entry         = pop ? entries_q[rd_ptr_q] : '0;
  assign rsp_exc_o         = rsp_entry.exc;
  assign rsp_upper_exc_o   = rsp_entry.upper;
  assign rsp_upper_exc_2_o = rsp_entry.upper_2;
  assign rsp_exc_valid_o   = pop;
  assign underflow_err_o   = underflow_q & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      entries_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      held_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && first_beat) held_q <= chk_entry;
      if (data_rvalid_i && empty) underflow_q <= 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
